multicycle_ctrl: RTL and testbench

- Multi-cycle CPU control FSM; sits directly upstream of the 32-bit ALU.
- Decodes opcode/funct from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives the ALU operation select (3-bit code), operand muxes, PC/IR/register-file/memory strobes.
- Consumes ALU zero/ovf for branch resolution and overflow trap.

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/multicycle_ctrl_if.sv | 37 +++
 rtl/alu_decode.sv | 26 ++
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path:
// opcodes, functs, ALU selects, FSM states and mux codes.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_NOT = 6'b100111;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_NOT = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_BEQ = 3'b110;
  localparam logic [2:0] ALU_BNE = 3'b111;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADDR = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC_R  = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_EXEC_I  = 4'd10;
  localparam logic [3:0] S_IWB     = 4'd11;
  localparam logic [3:0] S_TRAP    = 4'd12;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  localparam logic [1:0] SB_REGB = 2'b00;
  localparam logic [1:0] SB_FOUR = 2'b01;
  localparam logic [1:0] SB_IMM  = 2'b10;
  localparam logic [1:0] SB_IMM2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic       exc;
  } ctrl_t;

  function automatic logic is_wait_state(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle FSM and its datapath:
// decoded instruction fields and flags in, strobes and selects out.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       alu_ovf;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_sel;
  logic       exc;
  logic [3:0] state;

  modport master (
    input  opcode, funct, alu_zero, alu_ovf, mem_ready,
    output pc_write, pc_src, iord, mem_read, mem_write,
    output ir_write, reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, alu_sel, exc, state
  );

  modport slave (
    output opcode, funct, alu_zero, alu_ovf, mem_ready,
    input  pc_write, pc_src, iord, mem_read, mem_write,
    input  ir_write, reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, alu_sel, exc, state
  );
endinterface

// File: rtl/alu_decode.sv
// R-type funct decoder: ALU select code plus a legal flag
// used both for the illegal-instruction check and in execute.
module alu_decode
  import cpu_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_sel_o,
  output logic       legal_o
);

  // map funct to ALU op; unknown functs are flagged illegal
  always_comb begin
    alu_sel_o = ALU_ADD;
    legal_o   = 1'b1;
    unique case (1'b1)
      (funct_i == F_ADD): alu_sel_o = ALU_ADD;
      (funct_i == F_NOT): alu_sel_o = ALU_NOT;
      (funct_i == F_AND): alu_sel_o = ALU_AND;
      (funct_i == F_OR):  alu_sel_o = ALU_OR;
      (funct_i == F_SLT): alu_sel_o = ALU_SLT;
      (funct_i == F_SLL): alu_sel_o = ALU_SLL;
      default:            legal_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/mem/writeback
// sequencing with memory wait timeout and overflow trap.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [3:0]      state_q, state_d, dec_st;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]      r_sel;
  logic            r_legal, wait_st, tmo;
  ctrl_t           ctl;

  alu_decode u_alu_decode (
    .funct_i   (bus.funct),
    .alu_sel_o (r_sel),
    .legal_o   (r_legal)
  );

  assign wait_st = is_wait_state(state_q);
  assign tmo = TO_EN && wait_st && !bus.mem_ready
               && (cnt_q == TO_LAST);

  // next-state sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:
        if (bus.mem_ready) state_d = S_DECODE;
        else if (tmo)      state_d = S_TRAP;
      S_DECODE:
        case (bus.opcode)
          OP_RTYPE: state_d = r_legal ? S_EXEC_R : S_TRAP;
          OP_LW,
          OP_SW:    state_d = S_MEMADDR;
          OP_BEQ,
          OP_BNE:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  state_d = S_EXEC_I;
          default:  state_d = S_TRAP;
        endcase
      S_MEMADDR:
        if (bus.opcode == OP_LW)      state_d = S_MEMRD;
        else if (bus.opcode == OP_SW) state_d = S_MEMWR;
        else                          state_d = S_TRAP;
      S_MEMRD:
        if (bus.mem_ready) state_d = S_MEMWB;
        else if (tmo)      state_d = S_TRAP;
      S_MEMWB: state_d = S_FETCH;
      S_MEMWR:
        if (bus.mem_ready) state_d = S_FETCH;
        else if (tmo)      state_d = S_TRAP;
      S_EXEC_R:
        state_d = (bus.funct == F_ADD && bus.alu_ovf)
                  ? S_TRAP : S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_EXEC_I: state_d = bus.alu_ovf ? S_TRAP : S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_TRAP:   state_d = S_FETCH;
      default:  state_d = S_TRAP;
    endcase
  end

  // memory wait counter: counts stalled cycles, clears on any move
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (wait_st && !bus.mem_ready)
      cnt_d = cnt_q + TO_W'(1);
  end

  // state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // output decode; reset shows FETCH selects with strobes killed
  always_comb begin
    dec_st = rst ? S_FETCH : state_q;
    ctl = '0;
    case (dec_st)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SB_FOUR;
        ctl.alu_sel   = ALU_ADD;
        ctl.pc_src    = PC_ALU;
        ctl.ir_write  = bus.mem_ready;
        ctl.pc_write  = bus.mem_ready;
      end
      S_DECODE:  ctl.alu_src_b = SB_IMM2;
      S_MEMADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SB_IMM;
      end
      S_MEMRD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SB_REGB;
        ctl.alu_sel   = r_sel;
      end
      S_RWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_sel   = (bus.opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
        ctl.pc_src    = PC_ALUOUT;
        ctl.pc_write  = bus.alu_zero;
      end
      S_JUMP: begin
        ctl.pc_src   = PC_JUMP;
        ctl.pc_write = 1'b1;
      end
      S_EXEC_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SB_IMM;
      end
      S_IWB: ctl.reg_write = 1'b1;
      S_TRAP: begin
        ctl.exc      = 1'b1;
        ctl.pc_src   = PC_EXC;
        ctl.pc_write = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      ctl.pc_write  = 1'b0;
      ctl.ir_write  = 1'b0;
      ctl.reg_write = 1'b0;
      ctl.mem_read  = 1'b0;
      ctl.mem_write = 1'b0;
      ctl.exc       = 1'b0;
    end
  end

  assign bus.pc_write   = ctl.pc_write;
  assign bus.pc_src     = ctl.pc_src;
  assign bus.iord       = ctl.iord;
  assign bus.mem_read   = ctl.mem_read;
  assign bus.mem_write  = ctl.mem_write;
  assign bus.ir_write   = ctl.ir_write;
  assign bus.reg_dst    = ctl.reg_dst;
  assign bus.mem_to_reg = ctl.mem_to_reg;
  assign bus.reg_write  = ctl.reg_write;
  assign bus.alu_src_a  = ctl.alu_src_a;
  assign bus.alu_src_b  = ctl.alu_src_b;
  assign bus.alu_sel    = ctl.alu_sel;
  assign bus.exc        = ctl.exc;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table
// plus hand-written timeout and reset sequences, via a scoreboard.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] sel;
    logic       exc;
  } outs_t;

  typedef struct packed {
    logic [3:0] st;
    outs_t      o;
  } exp_t;

  typedef struct packed {
    logic       r;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       v;
    logic       rdy;
    exp_t       e;
  } vec_t;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2;
  localparam logic [3:0] MR = 4'd3, MB = 4'd4, MW = 4'd5;
  localparam logic [3:0] XR = 4'd6, RW = 4'd7, BR = 4'd8;
  localparam logic [3:0] JP = 4'd9, XI = 4'd10, IW = 4'd11;
  localparam logic [3:0] TR = 4'd12;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, BQ = 6'b000100;
  localparam logic [5:0] BN = 6'b000101, JJ = 6'b000010;
  localparam logic [5:0] AI = 6'b001000, BAD = 6'b111111;

  localparam logic [5:0] ADD = 6'b100000, NOTF = 6'b100111;
  localparam logic [5:0] SLT = 6'b101010, SLL = 6'b000000;
  localparam logic [5:0] ILL = 6'b100001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  outs_t O_RST, O_F1, O_F0, O_DE, O_MA, O_MR, O_MB;
  outs_t O_MW, O_RWB, O_JP, O_XI, O_IW, O_TR;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(
    .MEM_TIMEOUT (16),
    .TO_W        (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t o(
    input logic pcw, input logic [1:0] pcs, input logic iord,
    input logic mr, input logic mw, input logic irw,
    input logic rdst, input logic m2r, input logic rw,
    input logic sa, input logic [1:0] sb, input logic [2:0] sel,
    input logic exc);
    return {pcw, pcs, iord, mr, mw, irw, rdst, m2r, rw,
            sa, sb, sel, exc};
  endfunction

  function automatic outs_t ox(input logic [2:0] sel);
    return o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, sel, 0);
  endfunction

  function automatic outs_t obr(input logic pcw,
                                input logic [2:0] sel);
    return o(pcw, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, sel, 0);
  endfunction

  function automatic vec_t v(
    input logic r, input logic [5:0] op, input logic [5:0] fn,
    input logic z, input logic ov, input logic rdy,
    input logic [3:0] st, input outs_t oo);
    vec_t t;
    t.r = r; t.op = op; t.fn = fn;
    t.z = z; t.v = ov; t.rdy = rdy;
    t.e.st = st; t.e.o = oo;
    return t;
  endfunction

  task automatic step(input vec_t t, input string nm);
    exp_t  e;
    outs_t a;
    @(posedge clk);
    #1;
    rst           = t.r;
    bus.opcode    = t.op;
    bus.funct     = t.fn;
    bus.alu_zero  = t.z;
    bus.alu_ovf   = t.v;
    bus.mem_ready = t.rdy;
    exp_q.push_back(t.e);
    @(negedge clk);
    a = {bus.pc_write, bus.pc_src, bus.iord, bus.mem_read,
         bus.mem_write, bus.ir_write, bus.reg_dst,
         bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
         bus.alu_src_b, bus.alu_sel, bus.exc};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      if (bus.state !== e.st) begin
        errors++;
        $display("FAIL %s state got %0d want %0d",
                 nm, bus.state, e.st);
      end
      checks++;
      if (a !== e.o) begin
        errors++;
        $display("FAIL %s outs got %h want %h", nm, a, e.o);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.opcode    = RT;
    bus.funct     = ADD;
    bus.alu_zero  = 1'b0;
    bus.alu_ovf   = 1'b0;
    bus.mem_ready = 1'b1;

    O_RST = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    O_F1  = o(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    O_F0  = o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    O_DE  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    O_MA  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    O_MR  = o(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    O_MB  = o(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    O_MW  = o(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    O_RWB = o(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    O_JP  = o(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    O_XI  = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    O_IW  = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    O_TR  = o(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // reset
    tbl.push_back(v(1, RT, ADD, 0, 0, 1, FE, O_RST));
    // R add
    tbl.push_back(v(0, RT, ADD, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, RT, ADD, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, RT, ADD, 0, 0, 1, XR, ox(3'b000)));
    tbl.push_back(v(0, RT, ADD, 0, 0, 1, RW, O_RWB));
    // R add overflow traps
    tbl.push_back(v(0, RT, ADD, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, RT, ADD, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, RT, ADD, 0, 1, 1, XR, ox(3'b000)));
    tbl.push_back(v(0, RT, ADD, 0, 0, 1, TR, O_TR));
    // sll ignores overflow
    tbl.push_back(v(0, RT, SLL, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, RT, SLL, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, RT, SLL, 0, 1, 1, XR, ox(3'b101)));
    tbl.push_back(v(0, RT, SLL, 0, 0, 1, RW, O_RWB));
    // not, slt
    tbl.push_back(v(0, RT, NOTF, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, RT, NOTF, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, RT, NOTF, 0, 0, 1, XR, ox(3'b001)));
    tbl.push_back(v(0, RT, NOTF, 0, 0, 1, RW, O_RWB));
    tbl.push_back(v(0, RT, SLT, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, RT, SLT, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, RT, SLT, 0, 0, 1, XR, ox(3'b100)));
    tbl.push_back(v(0, RT, SLT, 0, 0, 1, RW, O_RWB));
    // illegal funct
    tbl.push_back(v(0, RT, ILL, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, RT, ILL, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, RT, ILL, 0, 0, 1, TR, O_TR));
    // lw with 3 wait cycles
    tbl.push_back(v(0, LW, 0, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, LW, 0, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, LW, 0, 0, 0, 1, MA, O_MA));
    tbl.push_back(v(0, LW, 0, 0, 0, 0, MR, O_MR));
    tbl.push_back(v(0, LW, 0, 0, 0, 0, MR, O_MR));
    tbl.push_back(v(0, LW, 0, 0, 0, 0, MR, O_MR));
    tbl.push_back(v(0, LW, 0, 0, 0, 1, MR, O_MR));
    tbl.push_back(v(0, LW, 0, 0, 0, 1, MB, O_MB));
    // sw
    tbl.push_back(v(0, SW, 0, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, SW, 0, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, SW, 0, 0, 0, 1, MA, O_MA));
    tbl.push_back(v(0, SW, 0, 0, 0, 1, MW, O_MW));
    // beq taken, bne not taken, bne taken
    tbl.push_back(v(0, BQ, 0, 1, 0, 1, FE, O_F1));
    tbl.push_back(v(0, BQ, 0, 1, 0, 1, DE, O_DE));
    tbl.push_back(v(0, BQ, 0, 1, 0, 1, BR, obr(1, 3'b110)));
    tbl.push_back(v(0, BN, 0, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, BN, 0, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, BN, 0, 0, 0, 1, BR, obr(0, 3'b111)));
    tbl.push_back(v(0, BN, 0, 1, 0, 1, FE, O_F1));
    tbl.push_back(v(0, BN, 0, 1, 0, 1, DE, O_DE));
    tbl.push_back(v(0, BN, 0, 1, 0, 1, BR, obr(1, 3'b111)));
    // jump
    tbl.push_back(v(0, JJ, 0, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, JJ, 0, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, JJ, 0, 0, 0, 1, JP, O_JP));
    // addi ok, addi overflow
    tbl.push_back(v(0, AI, 0, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, AI, 0, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, AI, 0, 0, 0, 1, XI, O_XI));
    tbl.push_back(v(0, AI, 0, 0, 0, 1, IW, O_IW));
    tbl.push_back(v(0, AI, 0, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, AI, 0, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, AI, 0, 0, 1, 1, XI, O_XI));
    tbl.push_back(v(0, AI, 0, 0, 0, 1, TR, O_TR));
    // unknown opcode
    tbl.push_back(v(0, BAD, 0, 0, 0, 1, FE, O_F1));
    tbl.push_back(v(0, BAD, 0, 0, 0, 1, DE, O_DE));
    tbl.push_back(v(0, BAD, 0, 0, 0, 1, TR, O_TR));

    foreach (tbl[i])
      step(tbl[i], $sformatf("vec%0d", i));

    // fetch timeout: 16 stalled cycles, trap on the 17th
    for (int i = 0; i < 16; i++)
      step(v(0, BAD, 0, 0, 0, 0, FE, O_F0), "tmo_wait");
    step(v(0, BAD, 0, 0, 0, 0, TR, O_TR), "tmo_trap");

    // ready on the last allowed cycle wins
    for (int i = 0; i < 15; i++)
      step(v(0, BAD, 0, 0, 0, 0, FE, O_F0), "late_wait");
    step(v(0, BAD, 0, 0, 0, 1, FE, O_F1), "late_rdy");
    step(v(0, BAD, 0, 0, 0, 1, DE, O_DE), "late_dec");
    step(v(0, BAD, 0, 0, 0, 1, TR, O_TR), "late_trap");

    // reset mid-wait clears the counter
    for (int i = 0; i < 5; i++)
      step(v(0, BAD, 0, 0, 0, 0, FE, O_F0), "rstf_pre");
    step(v(1, BAD, 0, 0, 0, 0, FE, O_RST), "rstf_rst");
    for (int i = 0; i < 16; i++)
      step(v(0, BAD, 0, 0, 0, 0, FE, O_F0), "rstf_wait");
    step(v(0, BAD, 0, 0, 0, 0, TR, O_TR), "rstf_trap");

    // reset during a stalled store
    step(v(0, SW, 0, 0, 0, 1, FE, O_F1), "rstw_fe");
    step(v(0, SW, 0, 0, 0, 1, DE, O_DE), "rstw_de");
    step(v(0, SW, 0, 0, 0, 1, MA, O_MA), "rstw_ma");
    step(v(0, SW, 0, 0, 0, 0, MW, O_MW), "rstw_mw");
    step(v(1, SW, 0, 0, 0, 0, MW, O_RST), "rstw_rst");
    step(v(0, SW, 0, 0, 0, 0, FE, O_F0), "rstw_fe2");
    step(v(0, SW, 0, 0, 0, 1, FE, O_F1), "rstw_fe3");
    step(v(0, SW, 0, 0, 0, 1, DE, O_DE), "rstw_de2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
